// File: rtl/task_responder_clkb.sv
// clkB-side executor of the task/acknowledge crossing: captures a command on each start
// pulse, runs one register-bus transaction under a timeout guard, and pulses TaskDone_clkB.
module task_responder_clkb #(
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_TIMEOUT    = 255
) (
    input  logic                    clkB,
    input  logic                    resetn_clkB,
    input  logic                    TaskStart_clkB,
    input  logic                    TaskBusy_clkB,
    output logic                    TaskDone_clkB,
    input  logic                    CmdWrite_clkB,
    input  logic [C_ADDR_WIDTH-1:0] CmdAddr_clkB,
    input  logic [C_DATA_WIDTH-1:0] CmdWdata_clkB,
    output logic [C_DATA_WIDTH-1:0] ResultRdata_clkB,
    output logic                    ResultErr_clkB,
    output logic                    ResultTimeout_clkB,
    output logic                    Overrun_clkB,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_write,
    output logic [C_ADDR_WIDTH-1:0] req_addr,
    output logic [C_DATA_WIDTH-1:0] req_wdata,
    input  logic                    rsp_valid,
    input  logic [C_DATA_WIDTH-1:0] rsp_rdata,
    input  logic                    rsp_err
);

    // A zero timeout still needs a one-bit counter so the ports elaborate.
    localparam int CntWidth = (C_TIMEOUT > 0) ? $clog2(C_TIMEOUT + 1) : 1;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(C_TIMEOUT);

    typedef enum logic [1:0] {
        Idle,
        Req,
        WaitRsp,
        Done
    } stateT;

    stateT                   state;
    stateT                   stateNext;
    logic [CntWidth-1:0]     timeoutCnt;
    logic                    expired;
    logic                    loadResult;
    logic [C_DATA_WIDTH-1:0] rdataNext;
    logic                    errNext;
    logic                    timeoutNext;
    logic                    unusedBusy;

    // Busy is already implied by the state; kept on the port for the crossing's interface.
    assign unusedBusy = TaskBusy_clkB;
    assign expired    = (C_TIMEOUT != 0) && (timeoutCnt == CntMax);

    always_comb begin
        stateNext     = state;
        loadResult    = 1'b0;
        rdataNext     = '0;
        errNext       = 1'b0;
        timeoutNext   = 1'b0;
        req_valid     = 1'b0;
        TaskDone_clkB = 1'b0;
        case (state)
            Idle: begin
                if (TaskStart_clkB) stateNext = Req;
            end
            Req: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    stateNext = WaitRsp;
                end else if (expired) begin
                    stateNext   = Done;
                    loadResult  = 1'b1;
                    errNext     = 1'b1;
                    timeoutNext = 1'b1;
                end
            end
            WaitRsp: begin
                if (rsp_valid) begin
                    stateNext  = Done;
                    loadResult = 1'b1;
                    rdataNext  = req_write ? '0 : rsp_rdata;
                    errNext    = rsp_err;
                end else if (expired) begin
                    stateNext   = Done;
                    loadResult  = 1'b1;
                    errNext     = 1'b1;
                    timeoutNext = 1'b1;
                end
            end
            Done: begin
                TaskDone_clkB = 1'b1;
                stateNext     = Idle;
            end
            default: stateNext = Idle;
        endcase
    end

    always_ff @(posedge clkB) begin
        if (!resetn_clkB) begin
            state              <= Idle;
            timeoutCnt         <= '0;
            req_write          <= 1'b0;
            req_addr           <= '0;
            req_wdata          <= '0;
            ResultRdata_clkB   <= '0;
            ResultErr_clkB     <= 1'b0;
            ResultTimeout_clkB <= 1'b0;
            Overrun_clkB       <= 1'b0;
        end else begin
            state <= stateNext;
            if (TaskStart_clkB && (state != Idle)) Overrun_clkB <= 1'b1;
            // The counter keeps running from REQ into WAIT_RSP and saturates at the limit.
            if (state == Idle) begin
                timeoutCnt <= '0;
                if (TaskStart_clkB) begin
                    req_write <= CmdWrite_clkB;
                    req_addr  <= CmdAddr_clkB;
                    req_wdata <= CmdWdata_clkB;
                end
            end else if (((state == Req) || (state == WaitRsp)) && (timeoutCnt != CntMax)) begin
                timeoutCnt <= timeoutCnt + 1'b1;
            end
            if (loadResult) begin
                ResultRdata_clkB   <= rdataNext;
                ResultErr_clkB     <= errNext;
                ResultTimeout_clkB <= timeoutNext;
            end
        end
    end

endmodule

// File: tb/tb_task_responder_clkb.sv
// Randomized scoreboard bench for task_responder_clkb: a transaction-level model predicts
// each task's result and latency; a monitor compares them whenever TaskDone_clkB pulses.
module tb_task_responder_clkb;

    localparam int TMO = 8;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          latency;
        int          startCyc;
    } expT;

    logic        clkB;
    logic        resetn_clkB;
    logic        TaskStart_clkB;
    logic        TaskBusy_clkB;
    logic        TaskDone_clkB;
    logic        CmdWrite_clkB;
    logic [7:0]  CmdAddr_clkB;
    logic [31:0] CmdWdata_clkB;
    logic [31:0] ResultRdata_clkB;
    logic        ResultErr_clkB;
    logic        ResultTimeout_clkB;
    logic        Overrun_clkB;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        zStart;
    logic        zDone;
    logic [31:0] zRdata;
    logic        zErr;
    logic        zTmo;
    logic        zOverrun;
    logic        zValid;
    logic        zWrite;
    logic [7:0]  zAddr;
    logic [31:0] zWdata;

    int  tests;
    int  failures;
    int  cyc;
    bit  expOverrun;
    expT sb[$];
    expT monEntry;

    task_responder_clkb #(.C_ADDR_WIDTH(8), .C_DATA_WIDTH(32), .C_TIMEOUT(TMO)) dut (
        .clkB(clkB), .resetn_clkB(resetn_clkB),
        .TaskStart_clkB(TaskStart_clkB), .TaskBusy_clkB(TaskBusy_clkB), .TaskDone_clkB(TaskDone_clkB),
        .CmdWrite_clkB(CmdWrite_clkB), .CmdAddr_clkB(CmdAddr_clkB), .CmdWdata_clkB(CmdWdata_clkB),
        .ResultRdata_clkB(ResultRdata_clkB), .ResultErr_clkB(ResultErr_clkB),
        .ResultTimeout_clkB(ResultTimeout_clkB), .Overrun_clkB(Overrun_clkB),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // Second instance with the timeout disabled; its bus never answers.
    task_responder_clkb #(.C_ADDR_WIDTH(8), .C_DATA_WIDTH(32), .C_TIMEOUT(0)) dutZero (
        .clkB(clkB), .resetn_clkB(resetn_clkB),
        .TaskStart_clkB(zStart), .TaskBusy_clkB(zStart), .TaskDone_clkB(zDone),
        .CmdWrite_clkB(1'b0), .CmdAddr_clkB(8'h33), .CmdWdata_clkB(32'h0),
        .ResultRdata_clkB(zRdata), .ResultErr_clkB(zErr),
        .ResultTimeout_clkB(zTmo), .Overrun_clkB(zOverrun),
        .req_valid(zValid), .req_ready(1'b0), .req_write(zWrite),
        .req_addr(zAddr), .req_wdata(zWdata),
        .rsp_valid(1'b0), .rsp_rdata(32'h0), .rsp_err(1'b0)
    );

    initial clkB = 1'b0;
    always #5 clkB = ~clkB;

    initial cyc = 0;
    always @(posedge clkB) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest predicted task.
    always @(negedge clkB) begin
        if (TaskDone_clkB) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                monEntry = sb.pop_front();
                checkOutput("result_rdata", ResultRdata_clkB, monEntry.rdata);
                checkOutput("result_err", ResultErr_clkB, monEntry.err);
                checkOutput("result_timeout", ResultTimeout_clkB, monEntry.tmo);
                checkOutput("done_latency", cyc - monEntry.startCyc, monEntry.latency);
                checkOutput("overrun", Overrun_clkB, expOverrun);
            end
        end
    end

    // One task: readyDelay = REQ cycles before req_ready, rspDelay = WAIT cycles before rsp_valid.
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                 input int readyDelay, input int rspDelay,
                                 input logic [31:0] rdata, input logic err, input bit doOverrun);
        expT e;
        bit  accepted;
        bit  done;
        int  rspTime;
        int  waitExpiry;
        int  doneRel;
        int  reqEnd;
        int  t;
        accepted = (readyDelay <= TMO);
        rspTime  = readyDelay + 1 + rspDelay;
        if (!accepted) begin
            doneRel = TMO + 1;
            e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1;
        end else begin
            waitExpiry = (TMO > readyDelay + 1) ? TMO : readyDelay + 1;
            if (rspTime <= waitExpiry) begin
                doneRel = rspTime + 1;
                e.rdata = wr ? 32'h0 : rdata; e.err = err; e.tmo = 1'b0;
            end else begin
                doneRel = waitExpiry + 1;
                e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1;
            end
        end
        reqEnd = accepted ? readyDelay : TMO;
        @(negedge clkB);
        CmdWrite_clkB  = wr;
        CmdAddr_clkB   = addr;
        CmdWdata_clkB  = wdata;
        TaskStart_clkB = 1'b1;
        TaskBusy_clkB  = 1'b1;
        e.startCyc = cyc;
        e.latency  = doneRel + 1;
        sb.push_back(e);
        done = 0;
        t = 0;
        while (!done && t < 100) begin
            @(negedge clkB);
            if (TaskDone_clkB) done = 1;
            TaskStart_clkB = doOverrun && accepted && (t == readyDelay + 1);
            if (TaskStart_clkB) expOverrun = 1'b1;
            req_ready = (t == readyDelay);
            rsp_valid = (t == rspTime) || ((t <= readyDelay) && ($urandom % 4 == 0));
            rsp_rdata = (t == rspTime) ? rdata : $urandom;
            rsp_err   = (t == rspTime) ? err : 1'($urandom);
            checkOutput("req_valid", req_valid, (t <= reqEnd) ? 64'd1 : 64'd0);
            checkOutput("req_write", req_write, wr);
            checkOutput("req_addr", req_addr, addr);
            checkOutput("req_wdata", req_wdata, wdata);
            t++;
        end
        if (!done) checkOutput("done_wait", 64'd0, 64'd1);
        TaskStart_clkB = 1'b0;
        TaskBusy_clkB  = 1'b0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int zDones;
        tests = 0; failures = 0; expOverrun = 1'b0;
        resetn_clkB = 1'b0; TaskStart_clkB = 1'b0; TaskBusy_clkB = 1'b0;
        CmdWrite_clkB = 1'b0; CmdAddr_clkB = '0; CmdWdata_clkB = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0; zStart = 1'b0;
        repeat (3) @(negedge clkB);
        checkOutput("reset_done", TaskDone_clkB, 0);
        checkOutput("reset_req_valid", req_valid, 0);
        checkOutput("reset_req_addr", req_addr, 0);
        checkOutput("reset_req_wdata", req_wdata, 0);
        checkOutput("reset_rdata", ResultRdata_clkB, 0);
        checkOutput("reset_err", ResultErr_clkB, 0);
        checkOutput("reset_timeout", ResultTimeout_clkB, 0);
        checkOutput("reset_overrun", Overrun_clkB, 0);
        resetn_clkB = 1'b1;

        applyStimulus(1'b0, 8'h10, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h20, 32'h5, TMO, 0, 32'hCAFEF00D, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h30, 32'h0, 30, 0, 32'h12345678, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h40, 32'h0, 2, 5, 32'hA5A5A5A5, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h41, 32'h0, 2, 6, 32'h5A5A5A5A, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h50, 32'h0, 1, 4, 32'h0BADF00D, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h51, 32'h77, 0, 1, 32'hFFFFFFFF, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom), 8'($urandom), $urandom, $urandom_range(0, 10),
                          $urandom_range(0, 9), $urandom, 1'($urandom), ($urandom % 8) == 0);
        end

        // Reset while the request is pending: no completion may follow.
        @(negedge clkB);
        CmdWrite_clkB = 1'b1; CmdAddr_clkB = 8'h66; CmdWdata_clkB = 32'h99;
        TaskStart_clkB = 1'b1; TaskBusy_clkB = 1'b1;
        @(negedge clkB);
        TaskStart_clkB = 1'b0;
        @(negedge clkB);
        checkOutput("pre_reset_req_valid", req_valid, 1);
        resetn_clkB = 1'b0;
        @(negedge clkB);
        checkOutput("mid_reset_req_valid", req_valid, 0);
        checkOutput("mid_reset_done", TaskDone_clkB, 0);
        checkOutput("mid_reset_overrun", Overrun_clkB, 0);
        checkOutput("mid_reset_err", ResultErr_clkB, 0);
        expOverrun = 1'b0;
        resetn_clkB = 1'b1; TaskBusy_clkB = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clkB);
            checkOutput("post_reset_quiet", TaskDone_clkB, 0);
        end
        applyStimulus(1'b0, 8'h70, 32'h0, 1, 2, 32'hFEEDFACE, 1'b0, 1'b0);

        @(negedge clkB);
        zStart = 1'b1;
        @(negedge clkB);
        zStart = 1'b0;
        zDones = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clkB);
            if (zDone) zDones++;
        end
        checkOutput("zero_tmo_no_done", zDones, 0);
        checkOutput("zero_tmo_req_valid", zValid, 1);

        repeat (3) @(negedge clkB);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
